// File: rtl/hazard_sched_if.sv
// Handshake bundle between the 5-stage pipeline datapath and hazard_sched.
// Latency: n/a (wires only). Backpressure: n/a; stage enables travel to the datapath on this bundle.
// master = pipeline datapath (drives ID decode fields, redirect, dmem ready)
// slave  = hazard_sched (drives enables, flushes, forward selects, timeout)
interface hazard_sched_if;
  logic       id_vld;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_rd_wren;
  logic       id_is_load;
  logic       id_is_mem;
  logic       ex_redirect;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       memwb_flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       dmem_timeout;

  modport master (
    output id_vld, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wren,
           id_is_load, id_is_mem, ex_redirect, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, fwd_a_sel, fwd_b_sel, dmem_timeout
  );

  modport slave (
    input  id_vld, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wren,
           id_is_load, id_is_mem, ex_redirect, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, fwd_a_sel, fwd_b_sel, dmem_timeout
  );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline sequencer for the RV32I 5-stage core: enables, flushes, load-use stall, dmem freeze, EX forwarding.
// Latency: control outputs are combinational from the shadow state and current inputs; shadow updates each edge.
// Backpressure: dmem not ready on a MEM-stage access freezes PC..EX/MEM and bubbles MEM/WB until ready.
// Ports: clk, reset (sync, active high); bus (hazard_sched_if.slave) carries ID decode fields,
//        EX redirect, dmem ready in; stage enables/flushes, forward selects, sticky dmem timeout out.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  hazard_sched_if.slave  bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
    logic       is_mem;
  } idex_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
    logic       is_mem;
  } exmem_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rd_wren;
  } memwb_t;

  idex_t          idex;
  exmem_t         exmem;
  memwb_t         memwb;
  logic [CW-1:0]  wait_cnt;
  logic           timeout;

  logic           freeze;
  logic           redirect;
  logic           ld_hit;
  logic           load_use;

  // EX/MEM wins over MEM/WB because it holds the younger producer.
  // A load in EX/MEM has no data yet; the load-use stall guarantees the
  // consumer picks it up from MEM/WB one cycle later instead.
  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] rs,
    input exmem_t     em,
    input memwb_t     mw
  );
    logic em_wr;
    logic mw_wr;
    em_wr = em.vld & em.rd_wren & (em.rd != 5'd0);
    mw_wr = mw.vld & mw.rd_wren & (mw.rd != 5'd0);
    if (!use_rs || rs == 5'd0) begin
      return 2'b00;
    end
    if (em_wr && em.rd == rs && !em.is_load) begin
      return 2'b01;
    end
    if (mw_wr && mw.rd == rs) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    freeze   = exmem.vld & exmem.is_mem & ~bus.dmem_ready;
    redirect = bus.ex_redirect & idex.vld & ~freeze;
    ld_hit   = idex.vld & idex.is_load & (idex.rd != 5'd0) & bus.id_vld &
               ((bus.id_use_rs1 & (bus.id_rs1 == idex.rd)) |
                (bus.id_use_rs2 & (bus.id_rs2 == idex.rd)));
    load_use = ld_hit & ~redirect & ~freeze;

    bus.pc_en        = ~freeze & ~load_use;
    bus.ifid_en      = ~freeze & ~load_use;
    bus.ifid_flush   = redirect;
    bus.idex_en      = ~freeze;
    bus.idex_flush   = redirect | load_use;
    bus.exmem_en     = ~freeze;
    bus.memwb_flush  = freeze;
    bus.dmem_timeout = timeout;

    // A bubble in EX reads nothing, so it never asks for a bypass.
    bus.fwd_a_sel = 2'b00;
    bus.fwd_b_sel = 2'b00;
    if (idex.vld) begin
      bus.fwd_a_sel = fwd_sel(idex.use_rs1, idex.rs1, exmem, memwb);
      bus.fwd_b_sel = fwd_sel(idex.use_rs2, idex.rs2, exmem, memwb);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex     <= '0;
      exmem    <= '0;
      memwb    <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (freeze) begin
      // ID/EX and EX/MEM hold; the stuck access must not retire twice.
      memwb.vld <= 1'b0;
      if (wait_cnt == CNT_LAST) begin
        timeout <= 1'b1;
      end
      if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end else begin
      wait_cnt <= '0;

      memwb.vld     <= exmem.vld;
      memwb.rd      <= exmem.rd;
      memwb.rd_wren <= exmem.rd_wren;

      exmem.vld     <= idex.vld;
      exmem.rd      <= idex.rd;
      exmem.rd_wren <= idex.rd_wren;
      exmem.is_load <= idex.is_load;
      exmem.is_mem  <= idex.is_mem;

      // Redirect squashes the wrong-path ID instruction; load-use inserts a
      // bubble while IF/ID holds the consumer for one more cycle.
      idex.vld     <= bus.id_vld & ~redirect & ~load_use;
      idex.rs1     <= bus.id_rs1;
      idex.rs2     <= bus.id_rs2;
      idex.use_rs1 <= bus.id_use_rs1;
      idex.use_rs2 <= bus.id_use_rs2;
      idex.rd      <= bus.id_rd;
      idex.rd_wren <= bus.id_rd_wren;
      idex.is_load <= bus.id_is_load;
      idex.is_mem  <= bus.id_is_mem;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed vector table, multi-cycle reset sequences, random run vs a pipeline model.
// Latency: outputs sampled 1 time unit after the falling edge, model advanced once per cycle.
// Backpressure: dmem ready is driven low in directed freeze/timeout rows and randomly in the random run.
module tb_hazard_sched;

  localparam int T = 4;

  localparam logic [11:0] NRM = 12'b1101010_00_00_0;
  localparam logic [11:0] FRZ = 12'b0000001_00_00_0;
  localparam logic [11:0] RED = 12'b1111110_00_00_0;
  localparam logic [11:0] LU  = 12'b0001110_00_00_0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_sched_if bus();

  hazard_sched #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [11:0] dut_o;
  assign dut_o = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.memwb_flush, bus.fwd_a_sel, bus.fwd_b_sel, bus.dmem_timeout};

  typedef struct {
    logic       id_vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       w;
    logic       ld;
    logic       mem;
    logic       redir;
    logic       rdy;
    logic [11:0] exp;
  } vec_t;

  // Model: one instruction record per stage beyond ID (0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit w;
    bit ld;
    bit mem;
  } ins_t;

  ins_t pipe[3];
  int   waits;
  bit   to_flag;

  int nvec = 0;
  int nmis = 0;

  function automatic logic [11:0] nf(int fa, int fb);
    return NRM | {7'b0, 2'(fa), 2'(fb), 1'b0};
  endfunction

  function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit w,
                              bit ld, bit mem, bit redir, bit rdy, logic [11:0] exp);
    vec_t r;
    r.id_vld = v;  r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
    r.rd = 5'(rd); r.w = w; r.ld = ld; r.mem = mem; r.redir = redir; r.rdy = rdy;
    r.exp = exp;
    return r;
  endfunction

  function automatic vec_t idle(bit rdy, logic [11:0] exp);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, exp);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    waits = 0;
    to_flag = 0;
  endfunction

  function automatic bit writes(ins_t e);
    return e.v && e.w && e.rd != 0;
  endfunction

  function automatic int src(int r, bit u);
    if (!pipe[0].v || !u || r == 0) return 0;
    if (writes(pipe[1]) && pipe[1].rd == r && !pipe[1].ld) return 1;
    if (writes(pipe[2]) && pipe[2].rd == r) return 2;
    return 0;
  endfunction

  function automatic void classify(vec_t v, output bit frz, output bit red, output bit lu);
    frz = pipe[1].v && pipe[1].mem && !v.rdy;
    red = !frz && v.redir && pipe[0].v;
    lu  = !frz && !red && v.id_vld && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
          ((v.u1 && int'(v.rs1) == pipe[0].rd) || (v.u2 && int'(v.rs2) == pipe[0].rd));
  endfunction

  function automatic logic [11:0] model_out(vec_t v);
    bit frz, red, lu;
    logic [11:0] base;
    classify(v, frz, red, lu);
    if (frz)      base = FRZ;
    else if (red) base = RED;
    else if (lu)  base = LU;
    else          base = NRM;
    return base | {7'b0, 2'(src(pipe[0].rs1, pipe[0].u1)), 2'(src(pipe[0].rs2, pipe[0].u2)),
                   to_flag};
  endfunction

  function automatic void model_adv(vec_t v);
    bit frz, red, lu;
    classify(v, frz, red, lu);
    if (frz) begin
      if (waits == T - 1) to_flag = 1;
      if (waits < T) waits++;
      pipe[2].v = 0;
    end else begin
      waits = 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: v.id_vld && !red && !lu, rs1: int'(v.rs1), rs2: int'(v.rs2),
                  u1: v.u1, u2: v.u2, rd: int'(v.rd), w: v.w, ld: v.ld, mem: v.mem};
    end
  endfunction

  task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b (pc ife iff ide idf exe mwf fa fb to)", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.id_vld      = v.id_vld;
    bus.id_rs1      = v.rs1;
    bus.id_rs2      = v.rs2;
    bus.id_use_rs1  = v.u1;
    bus.id_use_rs2  = v.u2;
    bus.id_rd       = v.rd;
    bus.id_rd_wren  = v.w;
    bus.id_is_load  = v.ld;
    bus.id_is_mem   = v.mem;
    bus.ex_redirect = v.redir;
    bus.dmem_ready  = v.rdy;
  endtask

  // One pipeline cycle: drive, settle, compare, then let the model take the edge.
  task automatic step(vec_t v, string nm, bit use_tab);
    @(negedge clk);
    drive(v);
    #1;
    check({nm, "/model"}, dut_o, model_out(v));
    if (use_tab) check({nm, "/table"}, dut_o, v.exp);
    model_adv(v);
  endtask

  task automatic do_reset(bit rdy);
    @(negedge clk);
    reset = 1'b1;
    drive(idle(rdy, NRM));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tab[$];
  vec_t rv;

  initial begin
    drive(idle(1, NRM));
    model_reset();

    // Idle after reset
    for (int i = 0; i < 5; i++) tab.push_back(idle(1, NRM));
    // ADD x5 ; SUB x6,x5,x7 (EX/MEM bypass) ; XOR x9,x1,x5 (MEM/WB bypass)
    tab.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, NRM));
    tab.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1, NRM));
    tab.push_back(mk(1, 1, 5, 1, 1, 9, 1, 0, 0, 0, 1, nf(1, 0)));
    tab.push_back(idle(1, nf(0, 2)));
    // rd = x0 producer, then readers of x0 at distance 1 and 2
    tab.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, NRM));
    tab.push_back(mk(1, 0, 3, 1, 1, 10, 1, 0, 0, 0, 1, NRM));
    tab.push_back(mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 0, 1, NRM));
    tab.push_back(idle(1, NRM));
    // LW x5 ; ADD x6,x5,x5 -> one stall cycle, then both operands from MEM/WB
    tab.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 1, 0, 1, NRM));
    tab.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, LU));
    tab.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, NRM));
    tab.push_back(idle(1, nf(2, 2)));
    // Redirect coinciding with a load-use hit: redirect wins, no stall
    tab.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 1, 0, 1, NRM));
    tab.push_back(mk(1, 7, 0, 1, 0, 8, 1, 0, 0, 1, 1, RED));
    // JAL x1 redirects and still writes x1; its target reads x1
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, NRM));
    tab.push_back(mk(1, 1, 0, 1, 0, 2, 1, 0, 0, 1, 1, RED));
    tab.push_back(mk(1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 1, NRM));
    tab.push_back(idle(1, nf(2, 0)));
    // SW (rs2 = x3 bypassed from MEM/WB), branch behind it, 3-cycle dmem wait
    tab.push_back(mk(1, 2, 3, 1, 1, 0, 0, 0, 1, 0, 1, NRM));
    tab.push_back(mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 1, nf(0, 2)));
    for (int i = 0; i < 3; i++) tab.push_back(mk(1, 9, 0, 1, 0, 12, 1, 0, 0, 1, 0, FRZ));
    tab.push_back(mk(1, 9, 0, 1, 0, 12, 1, 0, 0, 1, 1, RED));
    tab.push_back(idle(1, NRM));
    // LW stuck in MEM for T+1 cycles: timeout rises after the T-th freeze cycle
    tab.push_back(mk(1, 1, 0, 1, 0, 3, 1, 1, 1, 0, 1, NRM));
    tab.push_back(idle(1, NRM));
    for (int i = 0; i < T; i++) tab.push_back(idle(0, FRZ));
    tab.push_back(idle(0, FRZ | 12'h001));
    tab.push_back(idle(1, NRM | 12'h001));
    tab.push_back(idle(1, NRM | 12'h001));

    do_reset(1);
    for (int i = 0; i < tab.size(); i++) step(tab[i], $sformatf("tab%0d", i), 1);

    // Reset clears the sticky timeout
    do_reset(1);
    rv = idle(1, NRM);
    step(rv, "timeout_cleared", 1);

    // Reset in the middle of a freeze drops the stuck access
    rv = mk(1, 1, 0, 1, 0, 3, 1, 1, 1, 0, 1, NRM);
    step(rv, "mf_load", 1);
    rv = idle(1, NRM);
    step(rv, "mf_adv", 1);
    rv = idle(0, FRZ);
    step(rv, "mf_freeze", 1);
    do_reset(0);
    rv = idle(0, NRM);
    step(rv, "mf_after_reset", 1);

    // Random traffic with a narrow register range so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end
      rv.id_vld = ($urandom_range(0, 4) != 0);
      rv.rs1    = 5'($urandom_range(0, 3));
      rv.rs2    = 5'($urandom_range(0, 3));
      rv.u1     = $urandom_range(0, 1) == 1;
      rv.u2     = $urandom_range(0, 1) == 1;
      rv.rd     = 5'($urandom_range(0, 3));
      rv.w      = ($urandom_range(0, 3) != 0);
      rv.ld     = ($urandom_range(0, 2) == 0);
      rv.mem    = rv.ld || ($urandom_range(0, 4) == 0);
      rv.redir  = ($urandom_range(0, 6) == 0);
      rv.rdy    = ($urandom_range(0, 4) != 0);
      rv.exp    = NRM;
      step(rv, $sformatf("rand%0d", n), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
